// File: rtl/fifo_push_arbiter.sv
// fifo_push_arbiter: shares the single push port of one fifo among NUM_REQ
// producers. Round-robin arbitration, optional per-requester burst lock of up
// to MAX_BURST beats, no grant while the fifo is full or a flush is applied.
//
// Handshake: req_i[i] is the producer's valid and gnt_o[i] is its ready; a
// beat transfers in the same cycle both are high. gnt_o is one-hot or zero and
// is never raised while fifo_full_i, flush_i or reset is asserted.
//
// Optional feature: define FIFO_ARB_PERF_EN to build the per-requester 16-bit
// saturating grant counters on perf_cnt_o; otherwise perf_cnt_o is tied to 0.
// busy_o is the FSM state exposure (1 = LOCKED, 0 = ARB).
module fifo_push_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 8
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            flush_i,
    input  logic [NUM_REQ-1:0]              req_i,
    input  logic [NUM_REQ-1:0]              lock_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   data_i,
    output logic [NUM_REQ-1:0]              gnt_o,
    input  logic                            fifo_full_i,
    output logic                            fifo_push_o,
    output logic [DATA_WIDTH-1:0]           fifo_data_o,
    output logic [$clog2(NUM_REQ)-1:0]      owner_o,
    output logic                            busy_o,
    output logic [NUM_REQ*16-1:0]           perf_cnt_o
);

    localparam int IDX_W = $clog2(NUM_REQ);

    typedef enum logic {ARB, LOCKED} state_e;

    state_e           state_q;
    logic [IDX_W-1:0] rr_ptr_q;
    logic [IDX_W-1:0] owner_q;
    logic [7:0]       burst_cnt_q;

    logic             arb_found;
    logic [IDX_W-1:0] arb_idx;
    logic [IDX_W:0]   scan_sum;
    logic [NUM_REQ-1:0] gnt;
    logic             grant_any;
    logic [8:0]       burst_next;
    logic [IDX_W-1:0] rr_next;

    // Round-robin scan: first requester at or after rr_ptr_q, wrapping modulo NUM_REQ.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        scan_sum  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_sum = {1'b0, rr_ptr_q} + (IDX_W+1)'(k);
            if (scan_sum >= (IDX_W+1)'(NUM_REQ)) begin
                scan_sum = scan_sum - (IDX_W+1)'(NUM_REQ);
            end
            if (!arb_found && req_i[scan_sum[IDX_W-1:0]]) begin
                arb_found = 1'b1;
                arb_idx   = scan_sum[IDX_W-1:0];
            end
        end
    end

    // Same-cycle grant: ARB grants the scan winner, LOCKED grants only the owner.
    always_comb begin
        gnt = '0;
        if (rst_ni && !flush_i && !fifo_full_i) begin
            if (state_q == ARB) begin
                if (arb_found) begin
                    gnt[arb_idx] = 1'b1;
                end
            end else if (req_i[owner_q]) begin
                gnt[owner_q] = 1'b1;
            end
        end
    end

    // Data mux: forward the granted requester's word, zero when nothing is granted.
    always_comb begin
        fifo_data_o = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                fifo_data_o = data_i[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign grant_any   = |gnt;
    assign gnt_o       = gnt;
    assign fifo_push_o = grant_any;
    assign busy_o      = (state_q == LOCKED);
    assign owner_o     = (state_q == LOCKED) ? owner_q : arb_idx;
    assign burst_next  = {1'b0, burst_cnt_q} + 9'd1;
    assign rr_next     = (arb_idx == IDX_W'(NUM_REQ-1)) ? '0 : arb_idx + IDX_W'(1);

    // Arbiter FSM: pointer advance on ARB grants, burst lock bookkeeping, flush.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ARB;
            rr_ptr_q    <= '0;
            owner_q     <= '0;
            burst_cnt_q <= '0;
        end else if (flush_i) begin
            state_q     <= ARB;
            rr_ptr_q    <= '0;
            owner_q     <= '0;
            burst_cnt_q <= '0;
        end else begin
            case (state_q)
                ARB: begin
                    if (grant_any) begin
                        rr_ptr_q <= rr_next;
                        if (lock_i[arb_idx] && (MAX_BURST > 1)) begin
                            state_q     <= LOCKED;
                            owner_q     <= arb_idx;
                            burst_cnt_q <= 8'd1;
                        end
                    end
                end
                LOCKED: begin
                    if (!req_i[owner_q]) begin
                        // Owner dropped its request: release without a beat.
                        state_q     <= ARB;
                        burst_cnt_q <= '0;
                    end else if (grant_any) begin
                        if (!lock_i[owner_q] || (burst_next == 9'(MAX_BURST))) begin
                            state_q     <= ARB;
                            burst_cnt_q <= '0;
                        end else begin
                            burst_cnt_q <= burst_next[7:0];
                        end
                    end
                end
                default: begin
                    state_q <= ARB;
                end
            endcase
        end
    end

`ifdef FIFO_ARB_PERF_EN
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_perf
        logic [15:0] perf_q;

        // Saturating grant counter; survives flush, cleared only by reset.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                perf_q <= '0;
            end else if (gnt[g] && (perf_q != 16'hFFFF)) begin
                perf_q <= perf_q + 16'd1;
            end
        end

        assign perf_cnt_o[g*16 +: 16] = perf_q;
    end
`else
    assign perf_cnt_o = '0;
`endif

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// Bench for fifo_push_arbiter (NUM_REQ=4, DATA_WIDTH=32, MAX_BURST=8).
// A cycle model predicts grant/push/busy/data for every driven cycle; the
// prediction is queued and compared when the DUT outputs are sampled.
module tb_fifo_push_arbiter;

    localparam int NR   = 4;
    localparam int DW   = 32;
    localparam int MAXB = 8;
    localparam int W    = NR + 2 + DW;

    logic            clk_i = 1'b0;
    logic            rst_ni = 1'b0;
    logic            flush_i = 1'b0;
    logic [NR-1:0]   req_i = '0;
    logic [NR-1:0]   lock_i = '0;
    logic [NR*DW-1:0] data_i = '0;
    logic [NR-1:0]   gnt_o;
    logic            fifo_full_i = 1'b0;
    logic            fifo_push_o;
    logic [DW-1:0]   fifo_data_o;
    logic [1:0]      owner_o;
    logic            busy_o;
    logic [NR*16-1:0] perf_cnt_o;

    fifo_push_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(MAXB)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .flush_i     (flush_i),
        .req_i       (req_i),
        .lock_i      (lock_i),
        .data_i      (data_i),
        .gnt_o       (gnt_o),
        .fifo_full_i (fifo_full_i),
        .fifo_push_o (fifo_push_o),
        .fifo_data_o (fifo_data_o),
        .owner_o     (owner_o),
        .busy_o      (busy_o),
        .perf_cnt_o  (perf_cnt_o)
    );

    // Clock
    always #5 clk_i = ~clk_i;

    // Scoreboard and counters
    logic [W-1:0] exp_q[$];
    int           n_checks = 0;
    int           n_errors = 0;
    int           glog[$];

    // Reference model state
    int           m_locked, m_rr, m_owner, m_cnt;
    logic [15:0]  m_perf [NR];
    logic [DW-1:0] data_w [NR];

    int e_rr[8]     = '{0, 1, 2, 3, 0, 1, 2, 3};
    int e_alt[4]    = '{1, 3, 1, 3};
    int e_burst[10] = '{2, 2, 2, 2, 2, 2, 2, 2, 0, 1};
    int e_full[11]  = '{0, 0, -1, -1, -1, 0, 0, 0, 0, 0, 0};
    int e_flush[4]  = '{2, 2, -1, 0};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset(input bit keep_perf);
        m_locked = 0;
        m_rr     = 0;
        m_owner  = 0;
        m_cnt    = 0;
        if (!keep_perf) begin
            for (int i = 0; i < NR; i++) m_perf[i] = '0;
        end
    endtask

    // Drive one cycle, predict, compare, advance the model across the clock edge.
    task automatic step(input logic [NR-1:0] req, input logic [NR-1:0] lock,
                        input logic full, input logic flush);
        logic [NR-1:0] eg;
        logic [DW-1:0] ed;
        logic [W-1:0]  got;
        int            w;
        req_i       = req;
        lock_i      = lock;
        fifo_full_i = full;
        flush_i     = flush;
        for (int i = 0; i < NR; i++) begin
            data_w[i] = $urandom();
            data_i[i*DW +: DW] = data_w[i];
        end
        #1;
        w = -1;
        if (!full && !flush) begin
            if (m_locked != 0) begin
                if (req[m_owner]) w = m_owner;
            end else begin
                for (int k = 0; k < NR; k++) begin
                    if (w < 0 && req[(m_rr + k) % NR]) w = (m_rr + k) % NR;
                end
            end
        end
        eg = '0;
        ed = '0;
        if (w >= 0) begin
            eg[w] = 1'b1;
            ed    = data_w[w];
        end
        exp_q.push_back({eg, |eg, (m_locked != 0), ed});
        got = {gnt_o, fifo_push_o, busy_o, fifo_data_o};
        check("gnt_push_busy_data", 64'(got), 64'(exp_q.pop_front()));
        if (m_locked != 0) check("owner_locked", 64'(owner_o), 64'(m_owner));
        glog.push_back(w);
        // model next state
        if (flush) begin
            model_reset(1'b1);
        end else if (m_locked == 0) begin
            if (w >= 0) begin
                m_rr = (w + 1) % NR;
                if (lock[w] && MAXB > 1) begin
                    m_locked = 1;
                    m_owner  = w;
                    m_cnt    = 1;
                end
            end
        end else begin
            if (!req[m_owner]) begin
                m_locked = 0;
                m_cnt    = 0;
            end else if (w >= 0) begin
                m_cnt++;
                if (!lock[m_owner] || m_cnt == MAXB) begin
                    m_locked = 0;
                    m_cnt    = 0;
                end
            end
        end
`ifdef FIFO_ARB_PERF_EN
        if (w >= 0 && m_perf[w] != 16'hFFFF) m_perf[w] = m_perf[w] + 16'd1;
`endif
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    // Asynchronous reset asserted mid-cycle with requests pending.
    task automatic do_reset();
        req_i       = '1;
        lock_i      = '1;
        fifo_full_i = 1'b0;
        flush_i     = 1'b0;
        #2 rst_ni = 1'b0;
        #1;
        check("rst_gnt_push_busy_data", 64'({gnt_o, fifo_push_o, busy_o, fifo_data_o}), 64'd0);
        check("rst_owner", 64'(owner_o), 64'd0);
        check("rst_perf", 64'(perf_cnt_o), 64'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        model_reset(1'b0);
        glog.delete();
    endtask

    task automatic check_perf();
        for (int i = 0; i < NR; i++) begin
            check("perf_cnt", 64'(perf_cnt_o[i*16 +: 16]), 64'(m_perf[i]));
        end
    endtask

    initial begin
        model_reset(1'b0);
        @(negedge clk_i);
        do_reset();

        // Full rotation with all requesting
        for (int c = 0; c < 8; c++) step(4'b1111, 4'b0000, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) check("rr_order", 64'(glog[i]), 64'(e_rr[i]));

        // Sparse requests, pointer wraps 3 -> 0 and finds 1
        do_reset();
        for (int c = 0; c < 4; c++) step(4'b1010, 4'b0000, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) check("rr_wrap", 64'(glog[i]), 64'(e_alt[i]));

        // Burst lock on requester 2 for MAX_BURST beats, then resume rotation
        do_reset();
        step(4'b0010, 4'b0000, 1'b0, 1'b0);
        glog.delete();
        for (int c = 0; c < 10; c++) step(4'b0111, 4'b0100, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) check("burst_order", 64'(glog[i]), 64'(e_burst[i]));

        // Full for 3 cycles mid-lock: burst holds its count
        do_reset();
        for (int c = 0; c < 2; c++) step(4'b0001, 4'b0001, 1'b0, 1'b0);
        for (int c = 0; c < 3; c++) step(4'b0001, 4'b0001, 1'b1, 1'b0);
        check("busy_while_full", 64'(busy_o), 64'd1);
        for (int c = 0; c < 6; c++) step(4'b0001, 4'b0001, 1'b0, 1'b0);
        check("busy_after_burst", 64'(busy_o), 64'd0);
        for (int i = 0; i < 11; i++) check("full_order", 64'(glog[i]), 64'(e_full[i]));

        // Flush while locked
        do_reset();
        step(4'b0100, 4'b0100, 1'b0, 1'b0);
        step(4'b0100, 4'b0100, 1'b0, 1'b0);
        step(4'b0100, 4'b0100, 1'b0, 1'b1);
        check("busy_after_flush", 64'(busy_o), 64'd0);
        step(4'b1111, 4'b0000, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) check("flush_order", 64'(glog[i]), 64'(e_flush[i]));
        check_perf();

        // Random traffic against the model
        for (int c = 0; c < 400; c++) begin
            step(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 19) == 0));
        end
        check_perf();

        // Reset in the middle of a burst
        step(4'b0001, 4'b0001, 1'b0, 1'b0);
        step(4'b0001, 4'b0001, 1'b0, 1'b0);
        do_reset();
        step(4'b1111, 4'b0000, 1'b0, 1'b0);
        check("post_rst_grant", 64'(glog[0]), 64'd0);

        // Counter saturation (or tie-off when the counters are not built)
        req_i       = 4'b0001;
        lock_i      = '0;
        fifo_full_i = 1'b0;
        flush_i     = 1'b0;
`ifdef FIFO_ARB_PERF_EN
        repeat (70000) @(posedge clk_i);
        @(negedge clk_i);
        check("perf_saturate", 64'(perf_cnt_o[15:0]), 64'h0000_0000_0000_FFFF);
`else
        repeat (20) @(posedge clk_i);
        @(negedge clk_i);
        check("perf_tied_off", 64'(perf_cnt_o), 64'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
